// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Instruction decode stage of a small 16-register pipeline.
//   It holds the register file, selects operands (with optional same-cycle
//   write-back forwarding), detects load-use hazards against the instruction
//   in EX, and registers everything into the ID/EX pipeline register.
//
//   Parameters
//     DATA_W     register / operand width (16..64)
//     WB_BYPASS  1 = forward same-cycle write-back data to the read ports
//
//   Ports
//     clk, rst                         clock, async active-high reset
//     in_valid, in_instr               fetched instruction {op,rd,rs,rt}
//     flush                            discard the instruction in decode
//     ex_mem_read, ex_dst              load in EX and its destination
//     wb_we, wb_dst, wb_data           register-file write port
//     stall                            fetch must hold PC / in_instr
//     out_valid                        ID/EX holds a real instruction
//     out_opcode, out_dst              registered opcode / destination
//     out_src1, out_src2               registered operand data
//     out_we, out_mem_read,
//     out_mem_write, out_hlt           registered control
//     halted                           FSM state (1 = HALTED)
//
//   Flow control: an instruction presented with in_valid=1 is consumed on a
//   rising edge only when stall=0; while stall=1 fetch keeps in_instr
//   unchanged and the ID/EX register receives a bubble. flush overrides a
//   hazard stall and turns the current instruction into a bubble.
//
//   The FSM is one bit wide, so its state is exported directly on halted.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int DATA_W    = 16,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [3:0]        ex_dst,
  input  logic              wb_we,
  input  logic [3:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              out_valid,
  output logic [3:0]        out_opcode,
  output logic [3:0]        out_dst,
  output logic [DATA_W-1:0] out_src1,
  output logic [DATA_W-1:0] out_src2,
  output logic              out_we,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_hlt,
  output logic              halted
);

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_HALTED = 1'b1;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [16];
  logic              state_q, state_d;

  logic              out_valid_q, out_we_q, out_mem_read_q, out_mem_write_q, out_hlt_q;
  logic [3:0]        out_opcode_q, out_dst_q;
  logic [DATA_W-1:0] out_src1_q, out_src2_q;

  // ---------------------------------------------------------------------------
  // Field extraction and source selection
  // ---------------------------------------------------------------------------
  logic [3:0] opcode, f_rd, f_rs, f_rt;
  logic [3:0] idx1, idx2;
  logic       use1, use2;
  logic       writes_rf;

  assign opcode = in_instr[15:12];
  assign f_rd   = in_instr[11:8];
  assign f_rs   = in_instr[7:4];
  assign f_rt   = in_instr[3:0];

  always_comb begin
    idx1 = 4'd0;
    idx2 = 4'd0;
    use1 = 1'b0;
    use2 = 1'b0;
    if (opcode[3] == 1'b0) begin
      // ALU group 0000-0111
      idx1 = f_rs; use1 = 1'b1;
      idx2 = f_rt; use2 = 1'b1;
    end else begin
      case (opcode)
        OP_LW:  begin idx1 = f_rs; use1 = 1'b1; end
        // Store data register sits in the rd field.
        OP_SW:  begin idx1 = f_rs; use1 = 1'b1; idx2 = f_rd; use2 = 1'b1; end
        // LLB/LHB modify half of rd, so rd's old value is an operand.
        OP_LLB, OP_LHB: begin idx1 = f_rd; use1 = 1'b1; end
        OP_BR:  begin idx1 = f_rs; use1 = 1'b1; end
        default: ;
      endcase
    end
  end

  assign writes_rf = (opcode <= OP_LW) || (opcode == OP_LLB) ||
                     (opcode == OP_LHB) || (opcode == OP_PCS);

  // ---------------------------------------------------------------------------
  // Register read ports. Unused sources read as zero.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] src1_data, src2_data;

  always_comb begin
    src1_data = '0;
    if (use1 && idx1 != 4'd0) begin
      if (WB_BYPASS != 0 && wb_we && wb_dst == idx1) src1_data = wb_data;
      else                                           src1_data = regs_q[idx1];
    end
  end

  always_comb begin
    src2_data = '0;
    if (use2 && idx2 != 4'd0) begin
      if (WB_BYPASS != 0 && wb_we && wb_dst == idx2) src2_data = wb_data;
      else                                           src2_data = regs_q[idx2];
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard, issue and FSM
  // ---------------------------------------------------------------------------
  logic hazard, is_halted, issue;

  assign hazard = in_valid && ex_mem_read && (ex_dst != 4'd0) &&
                  ((use1 && idx1 == ex_dst) || (use2 && idx2 == ex_dst));

  assign is_halted = (state_q == ST_HALTED);

  // Only a valid, unflushed, hazard-free instruction in RUN reaches ID/EX.
  assign issue = !is_halted && in_valid && !flush && !hazard;

  // Gated with rst so fetch is never held while the pipeline is in reset.
  assign stall = !rst && (is_halted || (hazard && !flush));

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && issue && opcode == OP_HLT) state_d = ST_HALTED;
  end

  // ---------------------------------------------------------------------------
  // Register file: writes land in every state, stalled or not. R0 is never
  // written so it always reads zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (wb_we && wb_dst != 4'd0) begin
      regs_q[wb_dst] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX register. Data fields load unconditionally; on a bubble they are
  // don't-care and only valid/control are forced low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      out_valid_q     <= 1'b0;
      out_we_q        <= 1'b0;
      out_mem_read_q  <= 1'b0;
      out_mem_write_q <= 1'b0;
      out_hlt_q       <= 1'b0;
      out_opcode_q    <= 4'd0;
      out_dst_q       <= 4'd0;
      out_src1_q      <= '0;
      out_src2_q      <= '0;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= issue;
      out_we_q        <= issue && writes_rf;
      out_mem_read_q  <= issue && (opcode == OP_LW);
      out_mem_write_q <= issue && (opcode == OP_SW);
      out_hlt_q       <= issue && (opcode == OP_HLT);
      out_opcode_q    <= opcode;
      out_dst_q       <= f_rd;
      out_src1_q      <= src1_data;
      out_src2_q      <= src2_data;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_we        = out_we_q;
  assign out_mem_read  = out_mem_read_q;
  assign out_mem_write = out_mem_write_q;
  assign out_hlt       = out_hlt_q;
  assign out_opcode    = out_opcode_q;
  assign out_dst       = out_dst_q;
  assign out_src1      = out_src1_q;
  assign out_src2      = out_src2_q;
  assign halted        = is_halted;

endmodule
